// File: rtl/log_fir_tap_accumulator_if.sv
// Handshake bundle between the tap-multiplier array, the tap accumulator and
// the downstream consumer of filter samples.
interface log_fir_tap_accumulator_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ORD   = 64
);
  localparam int unsigned ACC_W = WIDTH + $clog2(ORD);

  logic                    in_valid;
  logic                    in_ready;
  logic [ORD*WIDTH-1:0]    tap_in_packed;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        y_out;
  logic [ACC_W-1:0]        y_full;
  logic                    sat;

  // Producer of tap vectors / consumer of results.
  modport master (
    output in_valid, tap_in_packed, out_ready,
    input  in_ready, out_valid, y_out, y_full, sat
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, tap_in_packed, out_ready,
    output in_ready, out_valid, y_out, y_full, sat
  );
endinterface

// File: rtl/log_fir_tap_accumulator.sv
// Sums ORD signed tap products, LANES per cycle, into a full-precision result
// plus a saturated WIDTH-bit sample, with valid/ready on both sides.
module log_fir_tap_accumulator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned QP    = 12,
  parameter int unsigned ORD   = 64,
  parameter int unsigned LANES = 8
) (
  input logic                     clk,
  input logic                     rst,
  log_fir_tap_accumulator_if.slave bus_io
);

  localparam int unsigned ACC_W = WIDTH + $clog2(ORD);
  localparam int unsigned NG    = ORD / LANES;
  localparam int unsigned CW    = (NG > 1) ? $clog2(NG) : 1;
  localparam int unsigned IW    = $clog2(ORD);

  localparam logic [CW-1:0] LastGrp = CW'(NG - 1);
  localparam logic signed [ACC_W-1:0] SatMax =
    {{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin =
    {{(ACC_W - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  // Elaboration-time sanity checks on the parameter set.
  if (QP >= WIDTH) begin : g_bad_qp
    $error("QP must be smaller than WIDTH");
  end
  if (ORD < 2 || LANES < 1 || LANES > ORD || (ORD % LANES) != 0) begin : g_bad_lanes
    $error("LANES must divide ORD and ORD must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] taps_q [ORD];
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]           grp_q, grp_d;
  logic signed [WIDTH-1:0] y_out_q, y_out_d;
  logic signed [ACC_W-1:0] y_full_q, y_full_d;
  logic                    sat_q, sat_d;
  logic signed [ACC_W-1:0] grp_sum, acc_sum;
  logic [IW-1:0]           idx;
  logic                    accept, load_vec;

  // Handshake flags come from registered state only (rst masks in_ready).
  assign bus_io.in_ready  = (state_q == StIdle) && !rst;
  assign bus_io.out_valid = (state_q == StHold);
  assign bus_io.y_out     = y_out_q;
  assign bus_io.y_full    = y_full_q;
  assign bus_io.sat       = sat_q;

  assign accept = bus_io.in_valid && bus_io.in_ready;

  // Sign-extended sum of the LANES taps of the current group, plus running total.
  always_comb begin
    grp_sum = '0;
    idx     = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      idx     = IW'(int'(grp_q) * int'(LANES) + l);
      grp_sum = grp_sum + {{(ACC_W - WIDTH){taps_q[idx][WIDTH-1]}}, taps_q[idx]};
    end
    acc_sum = acc_q + grp_sum;
  end

  // Next-state logic: accept, accumulate groups, hold result until consumed.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    grp_d    = grp_q;
    y_out_d  = y_out_q;
    y_full_d = y_full_q;
    sat_d    = sat_q;
    load_vec = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          load_vec = 1'b1;
          acc_d    = '0;
          grp_d    = '0;
          state_d  = StAccum;
        end
      end
      StAccum: begin
        acc_d = acc_sum;
        grp_d = grp_q + 1'b1;
        if (grp_q == LastGrp) begin
          grp_d    = '0;
          y_full_d = acc_sum;
          state_d  = StHold;
          if (acc_sum > SatMax) begin
            y_out_d = SatMax[WIDTH-1:0];
            sat_d   = 1'b1;
          end else if (acc_sum < SatMin) begin
            y_out_d = SatMin[WIDTH-1:0];
            sat_d   = 1'b1;
          end else begin
            y_out_d = acc_sum[WIDTH-1:0];
            sat_d   = 1'b0;
          end
        end
      end
      StHold: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and result registers, synchronous reset discards any sample in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      grp_q    <= '0;
      y_out_q  <= '0;
      y_full_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      grp_q    <= grp_d;
      y_out_q  <= y_out_d;
      y_full_q <= y_full_d;
      sat_q    <= sat_d;
    end
  end

  // Snapshot of the product vector so upstream is free to change it mid-sum.
  always_ff @(posedge clk) begin
    if (load_vec) begin
      for (int k = 0; k < int'(ORD); k++) begin
        taps_q[k] <= bus_io.tap_in_packed[WIDTH*k +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_log_fir_tap_accumulator.sv
// Directed bench for log_fir_tap_accumulator: default LANES=8 instance plus
// LANES=1 and LANES=64 instances fed the same vector for the latency sweep.
module tb_log_fir_tap_accumulator;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned ORD   = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 iv8, ivx, ordy;
  logic [ORD*WIDTH-1:0] vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  log_fir_tap_accumulator_if #(.WIDTH(WIDTH), .ORD(ORD)) b8  ();
  log_fir_tap_accumulator_if #(.WIDTH(WIDTH), .ORD(ORD)) b1  ();
  log_fir_tap_accumulator_if #(.WIDTH(WIDTH), .ORD(ORD)) b64 ();

  assign b8.in_valid       = iv8;
  assign b1.in_valid       = ivx;
  assign b64.in_valid      = ivx;
  assign b8.tap_in_packed  = vec;
  assign b1.tap_in_packed  = vec;
  assign b64.tap_in_packed = vec;
  assign b8.out_ready      = ordy;
  assign b1.out_ready      = ordy;
  assign b64.out_ready     = ordy;

  log_fir_tap_accumulator #(.WIDTH(WIDTH), .QP(12), .ORD(ORD), .LANES(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (b8)
  );
  log_fir_tap_accumulator #(.WIDTH(WIDTH), .QP(12), .ORD(ORD), .LANES(1)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (b1)
  );
  log_fir_tap_accumulator #(.WIDTH(WIDTH), .QP(12), .ORD(ORD), .LANES(64)) dut64 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (b64)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < int'(ORD); k++) vec[WIDTH*k +: WIDTH] = 16'(v);
  endtask

  // Offer one vector to the LANES=8 instance; n = edges after accept until out_valid.
  task automatic run8(output int n);
    iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    n = 0;
    while (!b8.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic chk_res(input string tag, input int yf, input int yo, input int s);
    chk({tag, "_y_full"}, $signed(b8.y_full), yf);
    chk({tag, "_y_out"},  $signed(b8.y_out),  yo);
    chk({tag, "_sat"},    {31'd0, b8.sat},    s);
  endtask

  initial begin
    int n;
    int lat8, lat1, lat64, yf1, yf64, yf8, nacc, rises;
    int acc_at [3];

    rst = 1'b1; iv8 = 1'b0; ivx = 1'b0; ordy = 1'b1; vec = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready_low", {31'd0, b8.in_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, b8.in_ready}, 1);
    chk("rst_out_valid", {31'd0, b8.out_valid}, 0);
    chk_res("rst", 0, 0, 0);

    // All taps +1.0: positive saturation
    set_all(4096);
    run8(n);
    chk("pos_latency", n, 8);
    chk_res("pos", 262144, 32767, 1);
    @(negedge clk);

    // All taps -1.0: negative saturation
    set_all(-4096);
    run8(n);
    chk("neg_latency", n, 8);
    chk_res("neg", -262144, -32768, 1);
    @(negedge clk);

    // Tap k = k on all three lane widths
    for (int k = 0; k < int'(ORD); k++) vec[WIDTH*k +: WIDTH] = 16'(k);
    iv8 = 1'b1; ivx = 1'b1;
    @(negedge clk);
    iv8 = 1'b0; ivx = 1'b0;
    lat8 = -1; lat1 = -1; lat64 = -1; yf8 = 0; yf1 = 0; yf64 = 0;
    for (int i = 0; i <= 80; i++) begin
      if (b8.out_valid && lat8 < 0)   begin lat8 = i;  yf8 = $signed(b8.y_full);  end
      if (b1.out_valid && lat1 < 0)   begin lat1 = i;  yf1 = $signed(b1.y_full);  end
      if (b64.out_valid && lat64 < 0) begin lat64 = i; yf64 = $signed(b64.y_full); end
      @(negedge clk);
    end
    chk("ramp_lat_l8", lat8, 8);
    chk("ramp_lat_l1", lat1, 64);
    chk("ramp_lat_l64", lat64, 1);
    chk("ramp_yfull_l8", yf8, 2016);
    chk("ramp_yfull_l1", yf1, 2016);
    chk("ramp_yfull_l64", yf64, 2016);
    chk("ramp_yout_l1", $signed(b1.y_out), 2016);
    chk("ramp_yout_l64", $signed(b64.y_out), 2016);
    chk_res("ramp", 2016, 2016, 0);

    // Alternating +0.5 / -0.5 cancels
    for (int k = 0; k < int'(ORD); k++) vec[WIDTH*k +: WIDTH] = (k % 2 == 0) ? 16'sd2048 : -16'sd2048;
    run8(n);
    chk("alt_latency", n, 8);
    chk_res("alt", 0, 0, 0);
    @(negedge clk);

    // Back-to-back with in_valid held high: accepts every 10 cycles
    nacc = 0;
    iv8 = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (b8.in_ready && nacc < 3) begin acc_at[nacc] = i; nacc++; end
      @(negedge clk);
    end
    iv8 = 1'b0;
    chk("b2b_accepts", nacc, 3);
    if (nacc == 3) begin
      chk("b2b_gap1", acc_at[1] - acc_at[0], 10);
      chk("b2b_gap2", acc_at[2] - acc_at[1], 10);
    end
    repeat (12) @(negedge clk);

    // Backpressure: result must hold while a new vector is waved at the block
    set_all(100);
    ordy = 1'b0;
    run8(n);
    chk("bp_latency", n, 8);
    chk_res("bp", 6400, 6400, 0);
    set_all(4096);
    for (int i = 0; i < 5; i++) begin
      iv8 = (i % 2 == 0);
      @(negedge clk);
      chk("bp_hold_out_valid", {31'd0, b8.out_valid}, 1);
      chk("bp_hold_in_ready", {31'd0, b8.in_ready}, 0);
      chk_res("bp_hold", 6400, 6400, 0);
    end
    set_all(7);
    iv8 = 1'b1;
    ordy = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", {31'd0, b8.out_valid}, 0);
    chk("bp_release_in_ready", {31'd0, b8.in_ready}, 1);
    @(negedge clk);
    iv8 = 1'b0;
    chk("bp_next_accepted", {31'd0, b8.in_ready}, 0);
    n = 0;
    while (!b8.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_next_latency", n, 8);
    chk_res("bp_next", 448, 448, 0);
    @(negedge clk);

    // Reset pulse during accumulation (after group 3 has been reached)
    set_all(4096);
    iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, b8.out_valid}, 0);
    chk_res("midrst", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, b8.in_ready}, 1);
    rises = 0;
    repeat (12) begin
      @(negedge clk);
      if (b8.out_valid) rises++;
    end
    chk("midrst_no_result", rises, 0);
    set_all(1);
    run8(n);
    chk("after_rst_latency", n, 8);
    chk_res("after_rst", 64, 64, 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
